// File: rtl/auth_reg_write_arbiter.sv
// rtl/auth_reg_write_arbiter.sv - round-robin arbiter in front of an ID-gated data register
//
// Purpose: NUM_REQ requesters compete for one protected register. The winner's
// ID and data are captured together, the ID is checked against AUTH_ID, and only
// an authorised request updates o_data_out. Requesters that are denied MAX_FAIL
// times in a row are locked out until reset.
//
// Ports:
//   i_clk       clock, all state on posedge
//   i_rst_n     asynchronous active-low reset
//   i_req       level request, one bit per requester
//   i_usr_id    packed IDs, requester i at [i*ID_W +: ID_W]
//   i_wdata     packed write data, requester i at [i*DATA_W +: DATA_W]
//   o_ack       1-cycle pulse: request i written
//   o_deny      1-cycle pulse: request i rejected
//   o_lockout   sticky: requester i is ignored
//   o_busy      high whenever the FSM is not idle
//   o_data_out  protected register
module auth_reg_write_arbiter #(
  parameter int              NUM_REQ  = 4,
  parameter int              DATA_W   = 8,
  parameter int              ID_W     = 3,
  parameter logic [ID_W-1:0] AUTH_ID  = 3'h4,
  parameter int              MAX_FAIL = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ID_W-1:0]   i_usr_id,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [NUM_REQ-1:0]        o_deny,
  output logic [NUM_REQ-1:0]        o_lockout,
  output logic                      o_busy,
  output logic [DATA_W-1:0]         o_data_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_DENY,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [IDX_W-1:0]    r_last_winner;
  logic [IDX_W-1:0]    r_win_idx;
  logic [ID_W-1:0]     r_win_id;
  logic [DATA_W-1:0]   r_win_data;
  logic                r_auth;
  logic [DATA_W-1:0]   r_data_out;
  logic [NUM_REQ-1:0]  r_lockout;
  logic [CNT_W-1:0]    r_fail_cnt [NUM_REQ];

  logic [NUM_REQ-1:0]  w_eligible;
  logic                w_found;
  logic [IDX_W-1:0]    w_pick;
  logic [ID_W-1:0]     w_sel_id;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_auth;
  logic [CNT_W-1:0]    w_fail_next;
  logic [NUM_REQ-1:0]  w_win_onehot;

  assign w_eligible = i_req & ~r_lockout;

  // Search starts just after the last winner so every eligible requester
  // gets a turn before a repeat winner.
  always_comb begin
    int v_cand;
    w_found = 1'b0;
    w_pick  = '0;
    v_cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_cand = (int'(r_last_winner) + k) % NUM_REQ;
      if (!w_found && w_eligible[v_cand]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(v_cand);
      end
    end
  end

  always_comb begin
    w_sel_id   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == IDX_W'(i)) begin
        w_sel_id   = i_usr_id[i*ID_W +: ID_W];
        w_sel_data = i_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // ID 0 is never authorised, even if AUTH_ID were misconfigured to 0.
  assign w_auth = (r_win_id == AUTH_ID) && (r_win_id != '0);

  assign w_fail_next = (r_fail_cnt[r_win_idx] == CNT_W'(MAX_FAIL)) ?
                       r_fail_cnt[r_win_idx] : r_fail_cnt[r_win_idx] + 1'b1;

  assign w_win_onehot = NUM_REQ'(1) << r_win_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_CHECK;
      S_CHECK: w_state_next = w_auth ? S_WRITE : S_DENY;
      S_WRITE: w_state_next = S_RESP;
      S_DENY:  w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_winner <= IDX_W'(NUM_REQ - 1);
      r_win_idx     <= '0;
      r_win_id      <= '0;
      r_win_data    <= '0;
      r_auth        <= 1'b0;
      r_data_out    <= '0;
      r_lockout     <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_fail_cnt[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // ID and data are latched on the same edge so the check and the
          // write always refer to one request.
          if (w_found) begin
            r_win_idx     <= w_pick;
            r_win_id      <= w_sel_id;
            r_win_data    <= w_sel_data;
            r_last_winner <= w_pick;
          end
        end
        S_CHECK: r_auth <= w_auth;
        S_WRITE: begin
          r_data_out            <= r_win_data;
          r_fail_cnt[r_win_idx] <= '0;
        end
        S_DENY: begin
          r_fail_cnt[r_win_idx] <= w_fail_next;
          if (w_fail_next == CNT_W'(MAX_FAIL)) r_lockout[r_win_idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ack      = (r_state == S_RESP && r_auth)  ? w_win_onehot : '0;
  assign o_deny     = (r_state == S_RESP && !r_auth) ? w_win_onehot : '0;
  assign o_lockout  = r_lockout;
  assign o_busy     = (r_state != S_IDLE);
  assign o_data_out = r_data_out;

endmodule
